// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (operando_A, operando_B, cod_operacion)
//   out_valid/out_ready result handshake (ALU_Result and flags)
//   ALU_Result          signed result
//   flag_zero/neg       result == 0 / result MSB
//   flag_carry          ADD carry out, SUB borrow (A < B unsigned), else 0
//   flag_ovf            signed overflow for ADD/SUB, else 0
//   err_op              result came from an unrecognised opcode
//   op_count            results consumed, wraps at 2^CNT_BITS
module alu_pipe #(
  parameter int NBITS    = 8,
  parameter int COD_OP   = 6,
  parameter int CNT_BITS = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [NBITS-1:0]    operando_A,
  input  logic signed [NBITS-1:0]    operando_B,
  input  logic        [COD_OP-1:0]   cod_operacion,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [NBITS-1:0]    ALU_Result,
  output logic                       flag_zero,
  output logic                       flag_neg,
  output logic                       flag_carry,
  output logic                       flag_ovf,
  output logic                       err_op,
  output logic        [CNT_BITS-1:0] op_count
);

  localparam logic [COD_OP-1:0] OP_ADD  = COD_OP'(6'b100000);
  localparam logic [COD_OP-1:0] OP_SUB  = COD_OP'(6'b100010);
  localparam logic [COD_OP-1:0] OP_AND  = COD_OP'(6'b100100);
  localparam logic [COD_OP-1:0] OP_OR   = COD_OP'(6'b100101);
  localparam logic [COD_OP-1:0] OP_XOR  = COD_OP'(6'b100110);
  localparam logic [COD_OP-1:0] OP_NOR  = COD_OP'(6'b100111);
  localparam logic [COD_OP-1:0] OP_SRA  = COD_OP'(6'b000011);
  localparam logic [COD_OP-1:0] OP_SRL  = COD_OP'(6'b000010);
  localparam logic [COD_OP-1:0] OP_SLL  = COD_OP'(6'b000000);
  localparam logic [COD_OP-1:0] OP_SLT  = COD_OP'(6'b101010);
  localparam logic [COD_OP-1:0] OP_SLTU = COD_OP'(6'b101011);

  // Shift amounts at or above this saturate (NBITS always fits in NBITS bits for NBITS >= 4).
  localparam logic [NBITS-1:0] SH_LIM = NBITS'(NBITS);

  typedef struct packed {
    logic signed [NBITS-1:0] res;
    logic                    zero;
    logic                    neg;
    logic                    carry;
    logic                    ovf;
    logic                    err;
  } alu_res_t;

  // Full ALU evaluation: result plus all status flags.
  function automatic alu_res_t alu_eval(input logic signed [NBITS-1:0] a,
                                        input logic signed [NBITS-1:0] b,
                                        input logic        [COD_OP-1:0] op);
    alu_res_t         r;
    logic [NBITS:0]   wide;
    logic [NBITS-1:0] b_u;
    logic             big_shift;
    r         = '0;
    wide      = '0;
    b_u       = $unsigned(b);
    big_shift = (b_u >= SH_LIM);
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.res   = wide[NBITS-1:0];
        r.carry = wide[NBITS];
        r.ovf   = (a[NBITS-1] == b[NBITS-1]) && (wide[NBITS-1] != a[NBITS-1]);
      end
      OP_SUB: begin
        // The extra top bit of the unsigned difference is the borrow.
        wide    = {1'b0, a} - {1'b0, b};
        r.res   = wide[NBITS-1:0];
        r.carry = wide[NBITS];
        r.ovf   = (a[NBITS-1] != b[NBITS-1]) && (wide[NBITS-1] != a[NBITS-1]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOR: r.res = ~(a | b);
      OP_SLL: begin
        if (big_shift) r.res = '0;
        else           r.res = a << b_u;
      end
      OP_SRL: begin
        if (big_shift) r.res = '0;
        else           r.res = $unsigned(a) >> b_u;
      end
      OP_SRA: begin
        // Kept as if/else: a ?: mixing with an unsigned replication would
        // turn the arithmetic shift into a logical one.
        if (big_shift) r.res = {NBITS{a[NBITS-1]}};
        else           r.res = a >>> b_u;
      end
      OP_SLT: begin
        r.res    = '0;
        r.res[0] = (a < b);
      end
      OP_SLTU: begin
        r.res    = '0;
        r.res[0] = ($unsigned(a) < $unsigned(b));
      end
      default: begin
        r.res = '1;
        r.err = 1'b1;
      end
    endcase
    r.zero = (r.res == '0);
    r.neg  = r.res[NBITS-1];
    return r;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [NBITS-1:0] a_p1;
  logic signed [NBITS-1:0] b_p1;
  logic        [COD_OP-1:0] op_p1;
  alu_res_t                res_p2;
  logic                    accept;
  logic                    load_p2;
  logic                    drain;

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign in_ready = !vld_p1 || !vld_p2 || out_ready;
  assign accept   = in_valid && in_ready;
  assign load_p2  = vld_p1 && (!vld_p2 || out_ready);
  assign drain    = vld_p2 && out_ready;

  // Stage 1: operand capture (data needs no reset, vld_p1 qualifies it)
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_p1  <= operando_A;
      b_p1  <= operando_B;
      op_p1 <= cod_operacion;
    end
  end

  // Stage 1/2 control, stage 2 result and counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      res_p2   <= '0;
      op_count <= '0;
    end else begin
      if (accept)       vld_p1 <= 1'b1;
      else if (load_p2) vld_p1 <= 1'b0;

      if (load_p2) begin
        res_p2 <= alu_eval(a_p1, b_p1, op_p1);
        vld_p2 <= 1'b1;
      end else if (drain) begin
        vld_p2 <= 1'b0;
      end

      if (drain) op_count <= op_count + CNT_BITS'(1);
    end
  end

  assign out_valid  = vld_p2;
  assign ALU_Result = res_p2.res;
  assign flag_zero  = res_p2.zero;
  assign flag_neg   = res_p2.neg;
  assign flag_carry = res_p2.carry;
  assign flag_ovf   = res_p2.ovf;
  assign err_op     = res_p2.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (NBITS=8): directed cases, backpressure, mid-flight
// reset and a randomized stream checked against an integer reference model.
module tb_alu_pipe;
  localparam int NBITS    = 8;
  localparam int COD_OP   = 6;
  localparam int CNT_BITS = 16;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  operando_A;
  logic [7:0]  operando_B;
  logic [5:0]  cod_operacion;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ALU_Result;
  logic        flag_zero;
  logic        flag_neg;
  logic        flag_carry;
  logic        flag_ovf;
  logic        err_op;
  logic [15:0] op_count;

  alu_pipe #(.NBITS(NBITS), .COD_OP(COD_OP), .CNT_BITS(CNT_BITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .operando_A(operando_A), .operando_B(operando_B), .cod_operacion(cod_operacion),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Result(ALU_Result), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf), .err_op(err_op),
    .op_count(op_count)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {err, ovf, carry, neg, zero, result[7:0]} from integer arithmetic.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    int sa, sb, ua, ub, r;
    bit err, v, c;
    logic [7:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    err = 0; v = 0; c = 0; r = 0;
    case (op)
      6'b100000: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      6'b100010: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b000011: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
      6'b000010: r = (ub >= 8) ? 0 : (ua >> ub);
      6'b000000: r = (ub >= 8) ? 0 : (ua << ub);
      6'b101010: r = (sa < sb) ? 1 : 0;
      6'b101011: r = (ua < ub) ? 1 : 0;
      default:   begin r = 255; err = 1; end
    endcase
    res = r[7:0];
    return {err, v, c, res[7], (res == 8'd0), res};
  endfunction

  // Scoreboard: accepted ops queued at the handshake, compared when drained.
  logic [12:0] expq[$];
  logic [15:0] mcnt;
  logic        hold;
  logic [12:0] held;
  logic [12:0] cur;
  logic [12:0] exp_v;

  assign cur = {err_op, flag_ovf, flag_carry, flag_neg, flag_zero, ALU_Result};

  initial begin
    mcnt = '0;
    hold = 1'b0;
    held = '0;
  end

  always @(negedge i_clk) begin
    if (i_reset) begin
      expq.delete();
      mcnt = '0;
      hold = 1'b0;
    end else begin
      check("op_count", op_count, mcnt);
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", cur, held);
      end
      if (in_valid && in_ready) expq.push_back(model(operando_A, operando_B, cod_operacion));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_v = expq.pop_front();
          check("sb_result", cur, exp_v);
        end
        mcnt = mcnt + 16'd1;
      end
      hold = out_valid && !out_ready;
      held = cur;
    end
  end

  // Present one operation and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic rdy;
    operando_A    = a;
    operando_B    = b;
    cod_operacion = op;
    in_valid      = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      rdy = in_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Single op on an idle pipe with out_ready=1; result must be valid 2 edges later.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                       input logic [7:0] er, input logic [4:0] ef, input string tag);
    operando_A    = a;
    operando_B    = b;
    cod_operacion = op;
    in_valid      = 1'b1;
    @(posedge i_clk);
    #1 in_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, ALU_Result, er);
    check({tag, "_flags"}, {err_op, flag_ovf, flag_carry, flag_neg, flag_zero}, ef);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 50 && expq.size() != 0; k++) @(posedge i_clk);
    #1 check(tag, expq.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] edges [5];
    edges[0] = 8'h00; edges[1] = 8'h7F; edges[2] = 8'h80; edges[3] = 8'hFF; edges[4] = 8'h01;
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  bit rnd_done;

  initial begin
    logic [5:0] ops [11];
    ops[0] = 6'b100000; ops[1] = 6'b100010; ops[2] = 6'b100100; ops[3] = 6'b100101;
    ops[4] = 6'b100110; ops[5] = 6'b100111; ops[6] = 6'b000011; ops[7] = 6'b000010;
    ops[8] = 6'b000000; ops[9] = 6'b101010; ops[10] = 6'b101011;

    i_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    operando_A = '0; operando_B = '0; cod_operacion = '0;
    rnd_done = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALU_Result, 0);
    check("rst_flags", {err_op, flag_ovf, flag_carry, flag_neg, flag_zero}, 0);
    check("rst_op_count", op_count, 0);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    @(posedge i_clk);
    #1 check("rst_in_ready", in_ready, 1);

    // Directed cases; flags are {err, ovf, carry, neg, zero}.
    do_op(8'h7F, 8'h01, OP_ADD,  8'h80, 5'b01010, "add_ovf");
    do_op(8'hFF, 8'h01, OP_ADD,  8'h00, 5'b00101, "add_carry");
    do_op(8'h03, 8'h05, OP_SUB,  8'hFE, 5'b00110, "sub_borrow");
    do_op(8'hFE, 8'h01, OP_SLT,  8'h01, 5'b00000, "slt");
    do_op(8'hFE, 8'h01, OP_SLTU, 8'h00, 5'b00001, "sltu");
    do_op(8'h80, 8'd3,  OP_SRA,  8'hF0, 5'b00010, "sra3");
    do_op(8'h80, 8'd3,  OP_SRL,  8'h10, 5'b00000, "srl3");
    do_op(8'h81, 8'd1,  OP_SLL,  8'h02, 5'b00000, "sll1");
    do_op(8'h80, 8'd9,  OP_SRA,  8'hFF, 5'b00010, "sra9");
    do_op(8'h80, 8'd8,  OP_SRL,  8'h00, 5'b00001, "srl8");
    do_op(8'h12, 8'h34, 6'b111111, 8'hFF, 5'b10010, "illegal");
    do_op(8'h01, 8'h01, OP_ADD,  8'h02, 5'b00000, "after_illegal");
    wait_drain("dir_drain");

    // Backpressure: five back-to-back ADDs with out_ready low for 4 edges.
    pulse_reset();
    @(posedge i_clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'(3 * i + 10), OP_ADD);
      end
      begin
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_op_count", op_count, 5);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(8'h10, 8'h20, OP_ADD);
    send(8'h01, 8'h02, OP_SUB);
    i_reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_result", ALU_Result, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 check("mid_rst_no_stale", out_valid, 0);
    do_op(8'h05, 8'h03, OP_SUB, 8'h02, 5'b00000, "post_rst");
    wait_drain("post_rst_drain");

    // Randomized stream with random backpressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [5:0] op;
          logic [7:0] a, b;
          if ($urandom_range(0, 11) == 11) op = 6'($urandom);
          else op = ops[$urandom_range(0, 10)];
          a = pick_operand();
          b = pick_operand();
          if ((op == OP_SRA || op == OP_SRL || op == OP_SLL) && $urandom_range(0, 1) == 0)
            b = 8'($urandom_range(0, 10));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge i_clk);
            #1;
          end
          send(a, b, op);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("rnd_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised two-stage pipelined successor of the combinational ALU, carrying the same operation encoding plus shift-left and set-less-than operations.
- Adds status flags, an illegal-opcode indication and a completed-operation counter.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the operand register bank and the result/display stage with backpressure.

Parameters:
- NBITS, 8, operand and result width (>=4).
- COD_OP, 6, opcode width.
- CNT_BITS, 16, width of the completed-operation counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block accepts this cycle.
- operando_A  input  NBITS  signed operand A.
- operando_B  input  NBITS  signed operand B; unsigned shift amount for shifts.
- cod_operacion  input  COD_OP  operation select.
- out_valid  output  1  result held on outputs.
- out_ready  input  1  consumer takes result this cycle.
- ALU_Result  output  NBITS  signed result.
- flag_zero  output  1  result == 0.
- flag_neg  output  1  result MSB.
- flag_carry  output  1  ADD: unsigned carry out; SUB: unsigned borrow (A<B); else 0.
- flag_ovf  output  1  signed overflow for ADD/SUB; else 0.
- err_op  output  1  result came from an unrecognised opcode.
- op_count  output  CNT_BITS  number of results consumed (out_valid & out_ready).

Behaviour:
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRA 000011, SRL 000010, SLL 000000.
  - SLT 101010: signed, result 1/0, zero-extended.
  - SLTU 101011: unsigned, result 1/0, zero-extended.
- Unrecognised opcode: ALU_Result = all ones, err_op = 1, other flags computed from that result (zero=0, neg=1, carry=0, ovf=0).
- Shifts: amount = operando_B treated unsigned at full width.
  - Amount >= NBITS: SLL/SRL give 0; SRA gives all copies of A's sign bit.
- ADD/SUB computed at NBITS+1 bits for carry/borrow. ovf for ADD: operands same sign, result sign differs. ovf for SUB: operands differ in sign, result sign differs from A.
- Stage 1 (S1): on in_valid & in_ready, register A, B and opcode; s1_valid set.
- Stage 2 (S2): computes on S1 contents, registers result, flags and err_op; s2_valid drives out_valid.
- Advance rules:
  - S2 loads when s1_valid & (!s2_valid | out_ready).
  - S2 clears when out_ready & out_valid with no S1 transfer.
  - in_ready = !s1_valid | !s2_valid | out_ready (combinational from out_ready only; no combinational path from in_valid).
- Latency: result valid on the 2nd rising edge after acceptance when out_ready is held 1. Throughput 1 op/cycle.
- Backpressure: out_valid, once asserted, holds ALU_Result and all flags stable until out_ready. No loss or duplication; order preserved.
- Simultaneous accept and drain in the same cycle is legal and must not stall.
- op_count increments on each out_valid & out_ready and wraps from 2^CNT_BITS-1 to 0.
- Reset (asynchronous, any time including mid-operation): s1_valid = s2_valid = 0, out_valid = 0. ALU_Result, all flags, err_op and op_count = 0. In-flight operations are discarded. in_ready = 1 from the first edge after reset release.

Test Plan:
- NBITS=8, out_ready=1: ADD 0x7F+0x01 -> after 2 edges ALU_Result=0x80, ovf=1, neg=1, carry=0, zero=0; ADD 0xFF+0x01 -> 0x00, zero=1, carry=1, ovf=0.
- SUB 0x03-0x05 -> 0xFE, carry(borrow)=1, neg=1; SLT 0xFE,0x01 -> 0x01; SLTU 0xFE,0x01 -> 0x00.
- Shifts: SRA 0x80 by 3 -> 0xF0; SRL 0x80 by 3 -> 0x10; SLL 0x81 by 1 -> 0x02; SRA 0x80 by 9 -> 0xFF; SRL 0x80 by 8 -> 0x00.
- Illegal opcode 111111 -> ALU_Result=0xFF, err_op=1; next op ADD 1+1 -> 0x02, err_op=0.
- Backpressure: stream 5 back-to-back ADDs with out_ready low for 4 cycles. Response: in_ready drops after 2 accepts, outputs stay stable, all 5 results later emerge in order, op_count=5.
- Assert i_reset while 2 ops are in flight -> out_valid=0 and op_count=0 immediately; no stale result after release.
